conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// Convolution tile sequencer: per kernel position it loads weights and activations into L0,
// runs the PE array, drains psums to pmem, then accumulates every output pixel across kij.
module conv_seq_ctrl #(
    parameter int          col      = 8,
    parameter int          row      = 8,
    parameter int          len_nij  = 36,
    parameter int          len_onij = 16,
    parameter int          len_kij  = 9,
    parameter logic [10:0] wt_base  = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [34:0] inst,
    output logic        busy,
    output logic [3:0]  kij,
    output logic        out_valid,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_WL0 = 4'd1, S_KLD = 4'd2, S_GAP = 4'd3, S_AL0 = 4'd4,
        S_EXE  = 4'd5, S_DRN = 4'd6, S_ACC = 4'd7, S_DONE = 4'd8
    } state_t;

    localparam logic [15:0] COL_W     = 16'(col);
    localparam logic [15:0] NIJ_W     = 16'(len_nij);
    localparam logic [15:0] WL0_LAST  = 16'(col + 1);
    localparam logic [15:0] KLD_LAST  = 16'(col + row - 1);
    localparam logic [15:0] GAP_LAST  = 16'd10;
    localparam logic [15:0] AL0_LAST  = 16'(len_nij + 1);
    localparam logic [15:0] EXE_LAST  = 16'(row + col + len_nij - 1);
    localparam logic [15:0] ACC_LAST  = 16'(len_kij);
    localparam logic [15:0] DONE_LAST = 16'd3;
    localparam logic [10:0] WT_HOLD   = 11'(col - 1);
    localparam logic [10:0] ONIJ      = 11'(len_onij);
    localparam logic [10:0] ONIJ_LAST = 11'(len_onij - 1);
    localparam logic [3:0]  KIJ_LAST  = 4'(len_kij - 1);
    localparam logic [34:0] IDLE_INST = {2'b00, 2'b11, 11'd0, 2'b11, 11'd0, 7'd0};

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [10:0] n_r, n_s;
    logic [3:0]  kij_r, kij_s;
    logic [34:0] inst_r, inst_s;
    logic        busy_r, done_r;
    logic [2:0]  ov_pipe_r;
    logic        ov_tap_s, done_tap_s;
    logic        bypass_s, acc_s, cen_p_s, wen_p_s, cen_x_s, wen_x_s;
    logic        ofifo_rd_s, l0_rd_s, l0_wr_s, exe_s, load_s;
    logic [10:0] a_p_s, a_x_s;

    // Next-state, counter updates and instruction decode for the current state.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + 16'd1;
        n_s        = n_r;
        kij_s      = kij_r;
        bypass_s   = 1'b0;
        acc_s      = 1'b0;
        cen_p_s    = 1'b1;
        wen_p_s    = 1'b1;
        a_p_s      = 11'd0;
        cen_x_s    = 1'b1;
        wen_x_s    = 1'b1;
        a_x_s      = 11'd0;
        ofifo_rd_s = 1'b0;
        l0_rd_s    = 1'b0;
        l0_wr_s    = 1'b0;
        exe_s      = 1'b0;
        load_s     = 1'b0;
        ov_tap_s   = 1'b0;
        done_tap_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_s = 16'd0;
                if (start) begin
                    state_s = S_WL0;
                    kij_s   = 4'd0;
                    n_s     = 11'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WL0: begin
                // The last weight address is held one extra cycle while L0 captures it.
                if (cnt_r < COL_W) begin
                    cen_x_s = 1'b0;
                    a_x_s   = wt_base + cnt_r[10:0];
                end else if (cnt_r == COL_W) begin
                    cen_x_s = 1'b0;
                    a_x_s   = wt_base + WT_HOLD;
                end else begin
                    cen_x_s = 1'b1;
                end
                l0_wr_s = (cnt_r != 16'd0) && (cnt_r <= COL_W);
                if (cnt_r == WL0_LAST) begin
                    state_s = S_KLD;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = S_WL0;
                end
            end
            S_KLD: begin
                load_s  = 1'b1;
                l0_rd_s = 1'b1;
                if (cnt_r == KLD_LAST) begin
                    state_s = S_GAP;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = S_KLD;
                end
            end
            S_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = S_AL0;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = S_GAP;
                end
            end
            S_AL0: begin
                if (cnt_r < NIJ_W) begin
                    cen_x_s = 1'b0;
                    a_x_s   = cnt_r[10:0];
                end else begin
                    cen_x_s = 1'b1;
                end
                l0_wr_s = (cnt_r != 16'd0) && (cnt_r <= NIJ_W);
                if (cnt_r == AL0_LAST) begin
                    state_s = S_EXE;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = S_AL0;
                end
            end
            S_EXE: begin
                exe_s   = 1'b1;
                l0_rd_s = 1'b1;
                if (cnt_r == EXE_LAST) begin
                    state_s = S_DRN;
                    cnt_s   = 16'd0;
                    n_s     = 11'd0;
                end else begin
                    state_s = S_EXE;
                end
            end
            S_DRN: begin
                // Drain waits on ofifo_valid indefinitely; the cycle after the last write is bypass-free.
                if (n_r == ONIJ) begin
                    cnt_s = 16'd0;
                    if (kij_r < KIJ_LAST) begin
                        state_s = S_WL0;
                        kij_s   = kij_r + 4'd1;
                    end else begin
                        state_s = S_ACC;
                        n_s     = 11'd0;
                    end
                end else begin
                    bypass_s = 1'b1;
                    if (ofifo_valid) begin
                        ofifo_rd_s = 1'b1;
                        cen_p_s    = 1'b0;
                        wen_p_s    = 1'b0;
                        a_p_s      = 11'(kij_r) * ONIJ + n_r;
                        n_s        = n_r + 11'd1;
                    end else begin
                        ofifo_rd_s = 1'b0;
                    end
                end
            end
            S_ACC: begin
                // n_r is the output pixel, cnt_r the step; the final step only closes the sum.
                if (cnt_r < ACC_LAST) begin
                    cen_p_s = 1'b0;
                    a_p_s   = cnt_r[10:0] * ONIJ + n_r;
                end else begin
                    cen_p_s = 1'b1;
                end
                acc_s = (cnt_r != 16'd0);
                if (cnt_r == ACC_LAST) begin
                    ov_tap_s = 1'b1;
                    cnt_s    = 16'd0;
                    if (n_r == ONIJ_LAST) begin
                        state_s = S_DONE;
                        n_s     = 11'd0;
                    end else begin
                        n_s = n_r + 11'd1;
                    end
                end else begin
                    state_s = S_ACC;
                end
            end
            S_DONE: begin
                // Hold in DONE so the last out_valid leaves the pipeline before done.
                done_tap_s = (cnt_r == 16'd2);
                if (cnt_r == DONE_LAST) begin
                    state_s = S_IDLE;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 16'd0;
            end
        endcase
        inst_s = {bypass_s, acc_s, cen_p_s, wen_p_s, a_p_s, cen_x_s, wen_x_s, a_x_s,
                  ofifo_rd_s, 1'b0, 1'b0, l0_rd_s, l0_wr_s, exe_s, load_s};
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= 16'd0;
            n_r       <= 11'd0;
            kij_r     <= 4'd0;
            inst_r    <= IDLE_INST;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ov_pipe_r <= 3'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            n_r       <= n_s;
            kij_r     <= kij_s;
            inst_r    <= inst_s;
            busy_r    <= (state_s != S_IDLE);
            done_r    <= done_tap_s;
            ov_pipe_r <= {ov_pipe_r[1:0], ov_tap_s};
        end
    end

    assign inst      = inst_r;
    assign busy      = busy_r;
    assign kij       = kij_r;
    assign out_valid = ov_pipe_r[2];
    assign done      = done_r;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: randomized ofifo_valid/start stimulus, observed
// instruction stream compared against expectations built from the sequencing rules.
module tb_conv_seq_ctrl;
    localparam int          COL  = 8;
    localparam int          ROW  = 8;
    localparam int          NIJ  = 36;
    localparam int          ONIJ = 16;
    localparam int          KIJ  = 9;
    localparam logic [10:0] WT   = 11'h400;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, ofifo_valid = 1'b0;
    logic [34:0] inst;
    logic        busy, out_valid, done;
    logic [3:0]  kij;

    conv_seq_ctrl #(.col(COL), .row(ROW), .len_nij(NIJ), .len_onij(ONIJ), .len_kij(KIJ),
                    .wt_base(WT)) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .kij(kij), .out_valid(out_valid), .done(done));

    int n_checks = 0, n_fail = 0, cyc = 0, vmode = 0;
    bit mon_en = 1'b0, tog = 1'b0;
    logic v_edge = 1'b0;
    int load_cnt[16], exec_cnt[16];
    int l0wr_n, l0rd_n, acc_n, bad_n;
    logic [10:0] wr_q[$], rd_q[$], xq[$];
    int wr_cyc_q[$], rd_cyc_q[$], ov_q[$], done_q[$];
    logic [3:0] wl_kij_q[$];

    initial forever #5 clk = ~clk;

    // ofifo_valid driver: constant 1, or random with strict alternation while kij==3
    initial forever begin
        @(posedge clk);
        #1;
        if (vmode == 0) ofifo_valid = 1'b1;
        else if (kij == 4'd3) begin tog = ~tog; ofifo_valid = tog; end
        else ofifo_valid = 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(posedge clk);
        v_edge = ofifo_valid;
    end

    // observer: records the instruction stream into event lists
    initial forever begin
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (inst[0]) load_cnt[kij]++;
            if (inst[1]) exec_cnt[kij]++;
            if (inst[2]) l0wr_n++;
            if (inst[3]) l0rd_n++;
            if (inst[33]) acc_n++;
            if (inst[4] || inst[5]) bad_n++;
            if (!inst[32] && !inst[31]) begin
                wr_q.push_back(inst[30:20]);
                wr_cyc_q.push_back(cyc);
                if (!inst[6] || !inst[34] || inst[33] || !v_edge) bad_n++;
            end else if (inst[6]) bad_n++;
            if (!inst[32] && inst[31]) begin
                rd_q.push_back(inst[30:20]);
                rd_cyc_q.push_back(cyc);
            end
            if (!inst[19]) begin
                if (!inst[18]) bad_n++;
                xq.push_back(inst[17:7]);
                if (inst[17:7] == WT) wl_kij_q.push_back(kij);
            end
            if (out_valid) ov_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
        end
    end

    function automatic logic [34:0] mk_idle();
        logic [34:0] v;
        v = '0;
        v[32] = 1'b1; v[31] = 1'b1; v[19] = 1'b1; v[18] = 1'b1;
        return v;
    endfunction

    task automatic clear_mon();
        for (int i = 0; i < 16; i++) begin load_cnt[i] = 0; exec_cnt[i] = 0; end
        l0wr_n = 0; l0rd_n = 0; acc_n = 0; bad_n = 0;
        wr_q.delete(); rd_q.delete(); xq.delete(); wr_cyc_q.delete(); rd_cyc_q.delete();
        ov_q.delete(); done_q.delete(); wl_kij_q.delete();
    endtask

    task automatic run_collect(input bit poke, output bit ok);
        clear_mon();
        mon_en = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (poke) start = inst[1] && ($urandom_range(0, 2) == 0);
            if (done) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] idle_inst;
        idle_inst = mk_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (inst !== idle_inst) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", inst, idle_inst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b ov=%b expected 0", done, out_valid); end
        n_checks++; if (kij !== 4'd0) begin n_fail++; $display("FAIL reset_kij: got %0d expected 0", kij); end
        reset = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || inst[0] !== 1'b1) begin n_fail++; $display("FAIL run_before_reset: got busy=%b load=%b expected 1", busy, inst[0]); end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_checks++; if (inst !== idle_inst) begin n_fail++; $display("FAIL midcycle_reset_inst: got %h expected %h", inst, idle_inst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midcycle_reset_busy: got %b expected 0", busy); end
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_run();
        bit ok;
        logic [10:0] exp_x[$];
        vmode = 0;
        run_collect(1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_run_timeout: got no done expected done"); end
        for (int k = 0; k < KIJ; k++) begin
            n_checks++; if (load_cnt[k] != COL + ROW) begin n_fail++; $display("FAIL load_cycles kij%0d: got %0d expected %0d", k, load_cnt[k], COL + ROW); end
            n_checks++; if (exec_cnt[k] != ROW + COL + NIJ) begin n_fail++; $display("FAIL exec_cycles kij%0d: got %0d expected %0d", k, exec_cnt[k], ROW + COL + NIJ); end
        end
        n_checks++; if (wr_q.size() != KIJ * ONIJ) begin n_fail++; $display("FAIL write_count: got %0d expected %0d", wr_q.size(), KIJ * ONIJ); end
        else for (int k = 0; k < KIJ; k++) for (int n = 0; n < ONIJ; n++) begin
            n_checks++; if (wr_q[k * ONIJ + n] != 11'(k * ONIJ + n)) begin n_fail++; $display("FAIL write_addr k%0d n%0d: got %0d expected %0d", k, n, wr_q[k * ONIJ + n], k * ONIJ + n); end
        end
        for (int k = 0; k < KIJ; k++) begin
            for (int c = 0; c < COL; c++) exp_x.push_back(WT + 11'(c));
            exp_x.push_back(WT + 11'(COL - 1));
            for (int c = 0; c < NIJ; c++) exp_x.push_back(11'(c));
        end
        n_checks++; if (xq.size() != exp_x.size()) begin n_fail++; $display("FAIL xmem_reads: got %0d expected %0d", xq.size(), exp_x.size()); end
        else for (int i = 0; i < exp_x.size(); i++) begin
            n_checks++; if (xq[i] != exp_x[i]) begin n_fail++; $display("FAIL xmem_addr %0d: got %h expected %h", i, xq[i], exp_x[i]); end
        end
        n_checks++; if (l0wr_n != KIJ * (COL + NIJ)) begin n_fail++; $display("FAIL l0_wr_cycles: got %0d expected %0d", l0wr_n, KIJ * (COL + NIJ)); end
        n_checks++; if (l0rd_n != KIJ * (2 * (COL + ROW) + NIJ)) begin n_fail++; $display("FAIL l0_rd_cycles: got %0d expected %0d", l0rd_n, KIJ * (2 * (COL + ROW) + NIJ)); end
        n_checks++; if (bad_n != 0) begin n_fail++; $display("FAIL strobe_rules: got %0d violations expected 0", bad_n); end
    endtask

    task automatic test_drain_gaps();
        bit ok;
        vmode = 1;
        run_collect(1'b1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL drain_run_timeout: got no done expected done"); end
        n_checks++; if (wr_q.size() != KIJ * ONIJ) begin n_fail++; $display("FAIL drain_write_count: got %0d expected %0d", wr_q.size(), KIJ * ONIJ); end
        else begin
            for (int n = 0; n < ONIJ; n++) begin
                n_checks++; if (wr_q[3 * ONIJ + n] != 11'(3 * ONIJ + n)) begin n_fail++; $display("FAIL kij3_addr n%0d: got %0d expected %0d", n, wr_q[3 * ONIJ + n], 3 * ONIJ + n); end
            end
            for (int n = 1; n < ONIJ; n++) begin
                n_checks++; if (wr_cyc_q[3 * ONIJ + n] - wr_cyc_q[3 * ONIJ + n - 1] < 2) begin n_fail++; $display("FAIL kij3_gap n%0d: got spacing %0d expected >=2", n, wr_cyc_q[3 * ONIJ + n] - wr_cyc_q[3 * ONIJ + n - 1]); end
            end
        end
        n_checks++; if (bad_n != 0) begin n_fail++; $display("FAIL drain_rules: got %0d violations expected 0", bad_n); end
        n_checks++; if (wl_kij_q.size() != KIJ) begin n_fail++; $display("FAIL kij_passes: got %0d expected %0d", wl_kij_q.size(), KIJ); end
        else for (int k = 0; k < KIJ; k++) begin
            n_checks++; if (wl_kij_q[k] != 4'(k)) begin n_fail++; $display("FAIL kij_order %0d: got %0d expected %0d", k, wl_kij_q[k], k); end
        end
        n_checks++; if (done_q.size() != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got %0d done busy=%b expected 1 done busy=0", done_q.size(), busy); end
    endtask

    task automatic test_acc_phase();
        bit ok;
        vmode = 1;
        run_collect(1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL acc_run_timeout: got no done expected done"); end
        n_checks++; if (rd_q.size() != KIJ * ONIJ) begin n_fail++; $display("FAIL acc_read_count: got %0d expected %0d", rd_q.size(), KIJ * ONIJ); end
        else for (int o = 0; o < ONIJ; o++) for (int j = 0; j < KIJ; j++) begin
            n_checks++; if (rd_q[o * KIJ + j] != 11'(j * ONIJ + o)) begin n_fail++; $display("FAIL acc_read o%0d j%0d: got %0d expected %0d", o, j, rd_q[o * KIJ + j], j * ONIJ + o); end
        end
        n_checks++; if (ov_q.size() != ONIJ) begin n_fail++; $display("FAIL out_valid_count: got %0d expected %0d", ov_q.size(), ONIJ); end
        else if (rd_cyc_q.size() == KIJ * ONIJ) for (int o = 0; o < ONIJ; o++) begin
            n_checks++; if (ov_q[o] <= rd_cyc_q[o * KIJ + KIJ - 1]) begin n_fail++; $display("FAIL out_valid_order o%0d: got cycle %0d expected after %0d", o, ov_q[o], rd_cyc_q[o * KIJ + KIJ - 1]); end
        end
        n_checks++; if (done_q.size() != 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", done_q.size()); end
        else if (ov_q.size() == ONIJ) begin
            n_checks++; if (done_q[0] <= ov_q[ONIJ - 1]) begin n_fail++; $display("FAIL done_after_ov: got %0d expected after %0d", done_q[0], ov_q[ONIJ - 1]); end
        end
        n_checks++; if (acc_n != ONIJ * KIJ) begin n_fail++; $display("FAIL acc_cycles: got %0d expected %0d", acc_n, ONIJ * KIJ); end
    endtask

    task automatic test_back_to_back();
        bit ok, saw_idle, relaunch;
        vmode = 1;
        clear_mon();
        mon_en = 1'b1;
        @(negedge clk) start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got no done expected done"); end
        saw_idle = 1'b0; relaunch = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!busy) saw_idle = 1'b1;
            else if (saw_idle) relaunch = 1'b1;
        end
        n_checks++; if (!saw_idle || !relaunch) begin n_fail++; $display("FAIL b2b_relaunch: got idle=%b relaunch=%b expected 1 1", saw_idle, relaunch); end
        repeat (4) @(negedge clk);
        n_checks++; if (wl_kij_q.size() != KIJ + 1) begin n_fail++; $display("FAIL b2b_passes: got %0d expected %0d", wl_kij_q.size(), KIJ + 1); end
        else begin
            n_checks++; if (wl_kij_q[KIJ] != 4'd0) begin n_fail++; $display("FAIL b2b_kij: got %0d expected 0", wl_kij_q[KIJ]); end
        end
        start = 1'b0;
        mon_en = 1'b0;
        reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_in_drain();
        bit found;
        logic [34:0] idle_inst;
        idle_inst = mk_idle();
        vmode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!inst[32] && !inst[31] && kij == 4'd4) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL drain_kij4_reached: got none expected write at kij 4"); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || kij !== 4'd0) begin n_fail++; $display("FAIL drain_reset: got busy=%b kij=%0d expected 0 0", busy, kij); end
        n_checks++; if (inst !== idle_inst) begin n_fail++; $display("FAIL drain_reset_inst: got %h expected %h", inst, idle_inst); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!inst[19]) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!found || inst[17:7] !== WT) begin n_fail++; $display("FAIL restart_addr: got found=%b addr=%h expected 1 %h", found, inst[17:7], WT); end
        n_checks++; if (kij !== 4'd0) begin n_fail++; $display("FAIL restart_kij: got %0d expected 0", kij); end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_drain_gaps();
        test_acc_phase();
        test_back_to_back();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
